multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Sits directly upstream of the datapath top. Consumes the opcode field of the instruction register, IR[31:26].
- Drives every datapath control strobe: PC, memory, IR, register file, ALU and PC-source muxes.
- Adds a memory-ready handshake so fetch and data accesses can stall. Also provides a retired-instruction counter.

Parameters:
- OP_RTYPE, 6'h00, opcode of R-type instructions.
- OP_LW, 6'h23, load word.
- OP_SW, 6'h2B, store word.
- OP_BEQ, 6'h04, branch if equal.
- OP_J, 6'h02, jump.
- OP_ADDI, 6'h08, add immediate.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- opcode  in  6  IR[31:26] from the datapath instruction register.
- mem_ready  in  1  memory has completed the current access this cycle.
- PCWriteCond  out  1  PC write if ALU zero (branch).
- PCWrite  out  1  unconditional PC write.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- MemToReg  out  1  write-back select: 0 = MDR, 1 = ALUOut.
- IRWrite  out  1  instruction register load.
- PCSource  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- ALUop  out  2  00 = add, 01 = sub, 10 = decode by funct.
- ALUSrcA  out  1  0 = PC, 1 = A register.
- ALUSrcB  out  2  00 = B register, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- RegWrite  out  1  register file write enable.
- RegDst  out  1  write address select: 0 = rt, 1 = rd.
- state_o  out  4  current state encoding (debug).
- instr_cnt  out  CNT_W  number of retired instructions.

Behaviour:
- State encoding:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, TRAP=12
- Reset:
  - While rst=0: state=FETCH, instr_cnt=0, and every control output is forced to 0.
  - The first rising edge after rst deasserts is the first FETCH cycle.
  - Asserting rst mid-instruction aborts it immediately. No partial write may follow.
- Outputs are Moore, decoded from state. Where noted, outputs are additionally gated by mem_ready. Any output not listed for a state is 0.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=00, PCSource=00.
  - IRWrite=PCWrite=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - ALUSrcA=0, ALUSrcB=11, ALUop=00.
  - Next state by opcode: LW/SW→MEMADR, RTYPE→EXEC, BEQ→BRANCH, J→JUMP, ADDI→ADDIEX, other→see optional feature.
- MEMADR:
  - ALUSrcA=1, ALUSrcB=10, ALUop=00.
  - Next state: LW→MEMRD, SW→MEMWR.
- MEMRD:
  - MemRead=1, IorD=1.
  - Holds until mem_ready=1, then goes to MEMWB.
- MEMWB:
  - RegWrite=1, RegDst=0, MemToReg=0.
  - Next state: FETCH.
- MEMWR:
  - MemWrite=1, IorD=1.
  - Holds until mem_ready=1, then goes to FETCH.
- EXEC:
  - ALUSrcA=1, ALUSrcB=00, ALUop=10.
  - Next state: RWB.
- RWB:
  - RegWrite=1, RegDst=1, MemToReg=1.
  - Next state: FETCH.
- BRANCH:
  - ALUSrcA=1, ALUSrcB=00, ALUop=01, PCWriteCond=1, PCSource=01.
  - Next state: FETCH.
- JUMP:
  - PCWrite=1, PCSource=10.
  - Next state: FETCH.
- ADDIEX:
  - ALUSrcA=1, ALUSrcB=10, ALUop=00.
  - Next state: ADDIWB.
- ADDIWB:
  - RegWrite=1, RegDst=0, MemToReg=1.
  - Next state: FETCH.
- Latency in cycles, with mem_ready held at 1:
  - LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3.
  - Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- opcode is sampled only in DECODE and MEMADR. It must stay stable because IR is not written outside FETCH.
- instr_cnt:
  - Increments by 1 on every transition into FETCH from MEMWB, MEMWR, RWB, BRANCH, JUMP or ADDIWB.
  - Wraps modulo 2^CNT_W.
  - Holds while stalled.
- MemRead and MemWrite are never both 1. RegWrite and a memory strobe are never both 1.

Optional Feature:
- Macro: MULTICYCLE_CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - An unknown opcode in DECODE goes to TRAP.
  - TRAP drives all control outputs 0 and is left only by reset.
  - An extra output port, illegal (1 bit), is 1 exactly while in TRAP.
  - instr_cnt does not increment for the trapped instruction.
- Undefined:
  - An unknown opcode in DECODE goes to FETCH and is treated as a NOP. It counts as retired.
  - There is no illegal port, and the TRAP state is unreachable.

Test Plan:
- Reset and release:
  - Stimulus: hold rst=0 for 3 cycles with mem_ready=1, then release.
  - Required: all outputs and instr_cnt are 0 during reset. The first cycle after release has state_o=0, MemRead=1, IRWrite=1, PCWrite=1, ALUSrcB=01.
- LW with stall:
  - Stimulus: opcode=6'h23, mem_ready=0 for 2 cycles in MEMRD.
  - Required: state sequence 0,1,2,3,3,3,4,0. MEMWB has RegWrite=1, RegDst=0, MemToReg=0. instr_cnt goes 0→1.
- SW:
  - Stimulus: opcode=6'h2B, mem_ready=1.
  - Required: states 0,1,2,5,0. MemWrite=1 and IorD=1 only in state 5. RegWrite never 1.
- R-type then ADDI:
  - Stimulus: R-type followed by ADDI.
  - Required: states 0,1,6,7,0,1,10,11,0. RWB has RegDst=1, MemToReg=1. ADDIWB has RegDst=0, MemToReg=1. instr_cnt=2.
- BEQ then J:
  - Stimulus: BEQ followed by J.
  - Required: BRANCH has PCWriteCond=1, ALUop=01, PCSource=01. JUMP has PCWrite=1, PCSource=10. Each instruction takes 3 cycles.
- Fetch stall, mid-instruction reset, illegal opcode:
  - Stimulus: mem_ready=0 in FETCH for 4 cycles, then rst=0 asserted in MEMRD, then opcode=6'h3F.
  - Required: IRWrite and PCWrite stay 0 until mem_ready=1. The reset returns to FETCH with instr_cnt=0. Opcode 6'h3F gives TRAP with illegal=1 if the macro is defined, otherwise returns to FETCH with instr_cnt+1.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath, with memory-ready stalls and a retired-instruction counter.
// Define MULTICYCLE_CTRL_ILLEGAL_TRAP_EN to trap unknown opcodes (adds the illegal output); otherwise they retire as NOPs.
module multicycle_ctrl #(
  parameter logic [5:0] OP_RTYPE = 6'h00,
  parameter logic [5:0] OP_LW    = 6'h23,
  parameter logic [5:0] OP_SW    = 6'h2B,
  parameter logic [5:0] OP_BEQ   = 6'h04,
  parameter logic [5:0] OP_J     = 6'h02,
  parameter logic [5:0] OP_ADDI  = 6'h08,
  parameter int         CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWriteCond,
  output logic             PCWrite,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemToReg,
  output logic             IRWrite,
  output logic [1:0]       PCSource,
  output logic [1:0]       ALUop,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic             RegWrite,
  output logic             RegDst,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] instr_cnt
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  ,
  output logic             illegal
`endif
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_RWB    = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;
  localparam logic [3:0] S_ADDIEX = 4'd10;
  localparam logic [3:0] S_ADDIWB = 4'd11;
  localparam logic [3:0] S_TRAP   = 4'd12;

  logic [3:0] state;
  logic [3:0] next_state;
  logic       retire;

  // retire marks the last cycle of an instruction, i.e. the edge that re-enters FETCH
  always_comb begin
    next_state = state;
    retire     = 1'b0;
    case (state)
      S_FETCH:  if (mem_ready) next_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_EXEC;
          OP_BEQ:       next_state = S_BRANCH;
          OP_J:         next_state = S_JUMP;
          OP_ADDI:      next_state = S_ADDIEX;
          default: begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
            next_state = S_TRAP;
`else
            next_state = S_FETCH;
            retire     = 1'b1;
`endif
          end
        endcase
      end
      S_MEMADR: next_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) next_state = S_MEMWB;
      S_MEMWB: begin
        next_state = S_FETCH;
        retire     = 1'b1;
      end
      S_MEMWR: begin
        if (mem_ready) begin
          next_state = S_FETCH;
          retire     = 1'b1;
        end
      end
      S_EXEC:   next_state = S_RWB;
      S_RWB: begin
        next_state = S_FETCH;
        retire     = 1'b1;
      end
      S_BRANCH: begin
        next_state = S_FETCH;
        retire     = 1'b1;
      end
      S_JUMP: begin
        next_state = S_FETCH;
        retire     = 1'b1;
      end
      S_ADDIEX: next_state = S_ADDIWB;
      S_ADDIWB: begin
        next_state = S_FETCH;
        retire     = 1'b1;
      end
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
      S_TRAP:   next_state = S_TRAP;
`else
      S_TRAP:   next_state = S_FETCH;
`endif
      default:  next_state = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_FETCH;
      instr_cnt <= '0;
    end else begin
      state <= next_state;
      if (retire) instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

  // Strobes are gated by rst directly so a mid-instruction reset cuts them off in the same cycle
  always_comb begin
    PCWriteCond = 1'b0;
    PCWrite     = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemToReg    = 1'b0;
    IRWrite     = 1'b0;
    PCSource    = 2'b00;
    ALUop       = 2'b00;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    if (rst) begin
      case (state)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE: ALUSrcB = 2'b11;
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEMWB:  RegWrite = 1'b1;
        S_MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        S_EXEC: begin
          ALUSrcA = 1'b1;
          ALUop   = 2'b10;
        end
        S_RWB: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
          MemToReg = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUop       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
        end
        S_JUMP: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
        end
        S_ADDIEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_ADDIWB: begin
          RegWrite = 1'b1;
          MemToReg = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state_o = state;

`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  assign illegal = rst && (state == S_TRAP);
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: instruction-level model of state sequences, strobes and retire count.
// Build with MULTICYCLE_CTRL_ILLEGAL_TRAP_EN defined to exercise the trap variant.
module tb_multicycle_ctrl;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [5:0]       opcode = 6'h00;
  logic             mem_ready = 1'b0;
  logic             PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemToReg, IRWrite;
  logic [1:0]       PCSource, ALUop, ALUSrcB;
  logic             ALUSrcA, RegWrite, RegDst;
  logic [3:0]       state_o;
  logic [CNT_W-1:0] instr_cnt;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  logic             illegal;
`endif

  int               n_cmp = 0;
  int               n_fail = 0;
  logic [CNT_W-1:0] model_cnt = '0;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .PCWriteCond(PCWriteCond), .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemToReg(MemToReg), .IRWrite(IRWrite), .PCSource(PCSource),
    .ALUop(ALUop), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
    .RegDst(RegDst), .state_o(state_o), .instr_cnt(instr_cnt)
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    , .illegal(illegal)
`endif
  );

  always #5 clk = ~clk;

  wire [15:0] dut_ctrl = {PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemToReg, IRWrite,
                          PCSource, ALUop, ALUSrcA, ALUSrcB, RegWrite, RegDst};

  // Strobe table per state number, straight from the state descriptions
  function automatic logic [15:0] exp_ctrl(input int st, input logic mr);
    logic pcwc = 0, pcw = 0, iord = 0, mrd = 0, mwr = 0, m2r = 0, irw = 0;
    logic asa = 0, rw = 0, rdst = 0;
    logic [1:0] pcs = 0, aop = 0, asb = 0;
    case (st)
      0:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mrd = 1; iord = 1; end
      4:  rw = 1;
      5:  begin mwr = 1; iord = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; rdst = 1; m2r = 1; end
      8:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      9:  begin pcw = 1; pcs = 2'b10; end
      10: begin asa = 1; asb = 2'b10; end
      11: begin rw = 1; m2r = 1; end
      default: ;
    endcase
    return {pcwc, pcw, irw == irw ? iord : iord, mrd, mwr, m2r, irw, pcs, aop, asa, asb, rw, rdst};
  endfunction

  // Runs one instruction: builds its expected state list from the latency rules, then drives and checks each cycle
  task automatic exec_instr(input logic [5:0] op, input int fstall, input int mstall);
    int   q_st[$];
    logic q_mr[$];
    bit   retires = 1'b1;
    for (int k = 0; k < fstall; k++) begin q_st.push_back(0); q_mr.push_back(1'b0); end
    q_st.push_back(0); q_mr.push_back(1'b1);
    q_st.push_back(1); q_mr.push_back(1'($urandom));
    case (op)
      6'h23: begin
        q_st.push_back(2); q_mr.push_back(1'($urandom));
        for (int k = 0; k < mstall; k++) begin q_st.push_back(3); q_mr.push_back(1'b0); end
        q_st.push_back(3); q_mr.push_back(1'b1);
        q_st.push_back(4); q_mr.push_back(1'($urandom));
      end
      6'h2B: begin
        q_st.push_back(2); q_mr.push_back(1'($urandom));
        for (int k = 0; k < mstall; k++) begin q_st.push_back(5); q_mr.push_back(1'b0); end
        q_st.push_back(5); q_mr.push_back(1'b1);
      end
      6'h00: begin q_st.push_back(6); q_mr.push_back(1'($urandom)); q_st.push_back(7); q_mr.push_back(1'($urandom)); end
      6'h08: begin q_st.push_back(10); q_mr.push_back(1'($urandom)); q_st.push_back(11); q_mr.push_back(1'($urandom)); end
      6'h04: begin q_st.push_back(8); q_mr.push_back(1'($urandom)); end
      6'h02: begin q_st.push_back(9); q_mr.push_back(1'($urandom)); end
      default: begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        for (int k = 0; k < 4; k++) begin q_st.push_back(12); q_mr.push_back(1'($urandom)); end
        retires = 1'b0;
`endif
      end
    endcase
    for (int i = 0; i < q_st.size(); i++) begin
      opcode    = op;
      mem_ready = q_mr[i];
      #1;
      n_cmp++;
      if (state_o !== 4'(q_st[i])) begin
        n_fail++;
        $display("[TB] FAIL state op=%h cyc=%0d: got %0d, want %0d", op, i, state_o, q_st[i]);
      end
      n_cmp++;
      if (dut_ctrl !== exp_ctrl(q_st[i], q_mr[i])) begin
        n_fail++;
        $display("[TB] FAIL ctrl op=%h cyc=%0d st=%0d: got %b, want %b", op, i, q_st[i], dut_ctrl, exp_ctrl(q_st[i], q_mr[i]));
      end
      n_cmp++;
      if (instr_cnt !== model_cnt) begin
        n_fail++;
        $display("[TB] FAIL instr_cnt op=%h cyc=%0d: got %0d, want %0d", op, i, instr_cnt, model_cnt);
      end
      n_cmp++;
      if ((MemRead && MemWrite) || (RegWrite && (MemRead || MemWrite))) begin
        n_fail++;
        $display("[TB] FAIL strobe_excl op=%h cyc=%0d: got Rd=%b Wr=%b RegW=%b, want no overlap", op, i, MemRead, MemWrite, RegWrite);
      end
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
      n_cmp++;
      if (illegal !== (q_st[i] == 12)) begin
        n_fail++;
        $display("[TB] FAIL illegal op=%h cyc=%0d: got %b, want %b", op, i, illegal, q_st[i] == 12);
      end
`endif
      @(negedge clk);
    end
    if (retires) model_cnt = model_cnt + 1'b1;
  endtask

  task automatic test_reset();
    mem_ready = 1'b1;
    rst       = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++;
      if (dut_ctrl !== 16'h0 || state_o !== 4'd0 || instr_cnt !== '0) begin
        n_fail++;
        $display("[TB] FAIL reset_hold cyc=%0d: got ctrl=%b st=%0d cnt=%0d, want all 0", c, dut_ctrl, state_o, instr_cnt);
      end
      @(negedge clk);
    end
    rst       = 1'b1;
    model_cnt = '0;
    #1;
    n_cmp++;
    if (state_o !== 4'd0 || !MemRead || !IRWrite || !PCWrite || ALUSrcB !== 2'b01) begin
      n_fail++;
      $display("[TB] FAIL reset_release: got st=%0d Rd=%b IRW=%b PCW=%b SrcB=%b, want 0 1 1 1 01",
               state_o, MemRead, IRWrite, PCWrite, ALUSrcB);
    end
  endtask

  task automatic test_lw_stall();       exec_instr(6'h23, 0, 2); endtask
  task automatic test_sw();             exec_instr(6'h2B, 0, 0); endtask
  task automatic test_rtype_addi();     exec_instr(6'h00, 0, 0); exec_instr(6'h08, 0, 0); endtask
  task automatic test_beq_j();          exec_instr(6'h04, 0, 0); exec_instr(6'h02, 0, 0); endtask
  task automatic test_fetch_stall();    exec_instr(6'h00, 4, 0); endtask

  task automatic test_mid_reset();
    int   seq[5] = '{0, 1, 2, 3, 3};
    logic mrs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    opcode = 6'h23;
    for (int i = 0; i < 5; i++) begin
      mem_ready = mrs[i];
      #1;
      n_cmp++;
      if (state_o !== 4'(seq[i])) begin
        n_fail++;
        $display("[TB] FAIL mid_reset_seq cyc=%0d: got %0d, want %0d", i, state_o, seq[i]);
      end
      @(negedge clk);
    end
    mem_ready = 1'b1;
    rst       = 1'b0;
    #1;
    n_cmp++;
    if (state_o !== 4'd0 || dut_ctrl !== 16'h0 || instr_cnt !== '0) begin
      n_fail++;
      $display("[TB] FAIL mid_reset_abort: got st=%0d ctrl=%b cnt=%0d, want 0 0 0", state_o, dut_ctrl, instr_cnt);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (state_o !== 4'd0 || dut_ctrl !== 16'h0 || instr_cnt !== '0) begin
      n_fail++;
      $display("[TB] FAIL mid_reset_hold: got st=%0d ctrl=%b cnt=%0d, want 0 0 0", state_o, dut_ctrl, instr_cnt);
    end
    @(negedge clk);
    rst       = 1'b1;
    model_cnt = '0;
    exec_instr(6'h2B, 1, 1);
  endtask

  task automatic test_random();
    logic [5:0] ops[9] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h3F, 6'h01, 6'h10};
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    int n_ops = 6;
`else
    int n_ops = 9;
`endif
    for (int n = 0; n < 40; n++)
      exec_instr(ops[$urandom_range(0, n_ops - 1)], $urandom_range(0, 3), $urandom_range(0, 3));
  endtask

  task automatic test_illegal();
    exec_instr(6'h3F, 0, 0);
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    rst = 1'b0;
    @(negedge clk);
    rst       = 1'b1;
    model_cnt = '0;
`endif
    exec_instr(6'h02, 0, 0);
  endtask

  initial begin
    #1 rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_lw_stall();
    test_sw();
    test_rtype_addi();
    test_beq_j();
    test_fetch_stall();
    test_mid_reset();
    test_random();
    test_illegal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
